// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EX and the data memory port.
// Validates and decodes one request, drives a single-cycle memory access, returns the result.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [2:0]  dm_rd_ctrl,
  output logic [2:0]  dm_wr_ctrl,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_din,
  input  logic [63:0] dm_dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state;
  logic [2:0] rd_ctrl_q;
  logic [2:0] wr_ctrl_q;
  logic [1:0] err_q;
  logic       capture;

  logic       illegal;
  logic       misaligned;
  logic [1:0] dec_err;
  logic [2:0] rd_code;
  logic [2:0] wr_code;

  always_comb begin
    illegal = (req_load == req_store) ||
              (req_load && (req_funct3 == 3'b111)) ||
              (req_store && req_funct3[2]);
    case (req_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = (req_addr[2:0] != 3'b000);
    endcase
    if (illegal)         dec_err = 2'b10;
    else if (misaligned) dec_err = 2'b01;
    else                 dec_err = 2'b00;

    case (req_funct3)
      3'b000:  rd_code = 3'b001;
      3'b100:  rd_code = 3'b010;
      3'b001:  rd_code = 3'b011;
      3'b101:  rd_code = 3'b100;
      3'b010:  rd_code = 3'b101;
      3'b110:  rd_code = 3'b110;
      3'b011:  rd_code = 3'b111;
      default: rd_code = 3'b000;
    endcase
    wr_code = {1'b0, req_funct3[1:0]} + 3'd1;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // Reset gates the controls immediately so an access cycle cut by reset never reaches memory.
  assign dm_rd_ctrl = rst_n ? rd_ctrl_q : 3'b000;
  assign dm_wr_ctrl = rst_n ? wr_ctrl_q : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ctrl_q  <= '0;
      wr_ctrl_q  <= '0;
      err_q      <= '0;
      capture    <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= '0;
      dm_addr    <= '0;
      dm_din     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Rejected requests also spend one cycle in ACCESS (with idle controls)
            // so every request answers one edge after the access slot.
            state   <= ACCESS;
            err_q   <= dec_err;
            capture <= (dec_err == 2'b00) && req_load;
            if (dec_err == 2'b00) begin
              dm_addr   <= req_addr;
              dm_din    <= req_wdata;
              rd_ctrl_q <= req_load  ? rd_code : 3'b000;
              wr_ctrl_q <= req_store ? wr_code : 3'b000;
            end
          end
        end
        ACCESS: begin
          resp_rdata <= capture ? dm_dout : '0;
          resp_err   <= err_q;
          rd_ctrl_q  <= '0;
          wr_ctrl_q  <= '0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte memory model on the falling edge, queued expectations
// checked by a monitor at each response handoff.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [2:0]  dm_rd_ctrl;
  logic [2:0]  dm_wr_ctrl;
  logic [63:0] dm_addr;
  logic [63:0] dm_din;
  logic [63:0] dm_dout;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  err;
    logic [2:0]  rc;
    logic [2:0]  wc;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Memory model: acts on the falling edge, performs the load extension itself.
  logic [7:0] mem [0:1023];
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  logic [2:0] rd_seen = '0;
  logic [2:0] wr_seen = '0;

  function automatic logic [63:0] load_val(input logic [2:0] c, input logic [9:0] a);
    logic [63:0] d;
    for (int unsigned i = 0; i < 8; i++) d[8*i +: 8] = mem[a + 10'(i)];
    case (c)
      3'b001:  return {{56{d[7]}}, d[7:0]};
      3'b010:  return {56'd0, d[7:0]};
      3'b011:  return {{48{d[15]}}, d[15:0]};
      3'b100:  return {48'd0, d[15:0]};
      3'b101:  return {{32{d[31]}}, d[31:0]};
      3'b110:  return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

  function automatic int unsigned wr_bytes(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b011:  return 4;
      default: return 8;
    endcase
  endfunction

  always @(negedge clk) begin
    if (dm_rd_ctrl != 3'b000) begin
      rd_cnt  <= rd_cnt + 1;
      rd_seen <= dm_rd_ctrl;
      dm_dout <= load_val(dm_rd_ctrl, dm_addr[9:0]);
    end
    if (dm_wr_ctrl != 3'b000) begin
      wr_cnt  <= wr_cnt + 1;
      wr_seen <= dm_wr_ctrl;
      for (int unsigned i = 0; i < 8; i++)
        if (i < wr_bytes(dm_wr_ctrl)) mem[dm_addr[9:0] + 10'(i)] <= dm_din[8*i +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one pop per response handoff; also checks the dm pulses since the previous one.
  initial begin
    exp_t e;
    int rd_base = 0;
    int wr_base = 0;
    forever begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          chk({e.name, ".rdata"}, resp_rdata, e.rdata);
          chk({e.name, ".err"}, 64'(resp_err), 64'(e.err));
          chk({e.name, ".rd_pulses"}, 64'(rd_cnt - rd_base), (e.rc != 3'b000) ? 64'd1 : 64'd0);
          chk({e.name, ".wr_pulses"}, 64'(wr_cnt - wr_base), (e.wc != 3'b000) ? 64'd1 : 64'd0);
          if (e.rc != 3'b000) chk({e.name, ".rd_code"}, 64'(rd_seen), 64'(e.rc));
          if (e.wc != 3'b000) chk({e.name, ".wr_code"}, 64'(wr_seen), 64'(e.wc));
          rd_base = rd_cnt;
          wr_base = wr_cnt;
        end
      end
    end
  end

  task automatic wait_ready(input string name, output logic ok);
    int unsigned n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = req_ready;
    if (!ok) chk({name, ".ready_timeout"}, 64'(req_ready), 64'(1));
  endtask

  task automatic issue(input string name, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] exp_rd,
                       input logic [1:0] exp_err, input logic [2:0] rc, input logic [2:0] wc,
                       input int unsigned stall);
    exp_t e;
    logic ok;
    wait_ready(name, ok);
    if (!ok) return;
    e.rdata = exp_rd; e.err = exp_err; e.rc = rc; e.wc = wc; e.name = name;
    sb.push_back(e);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; resp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, ".lat_access"}, 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    chk({name, ".lat_resp"}, 64'(resp_valid), 64'(1));
    if (stall > 0) begin
      // A competing lwu sits on the request port for the whole stall.
      req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
      req_funct3 = 3'b110; req_addr = 64'h8000_0104;
      for (int unsigned i = 0; i < stall; i++) begin
        chk({name, ".hold_valid"}, 64'(resp_valid), 64'(1));
        chk({name, ".hold_rdata"}, resp_rdata, exp_rd);
        chk({name, ".hold_ready"}, 64'(req_ready), 64'(0));
        @(posedge clk); #1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, ".resp_valid"}, 64'(resp_valid), 64'(0));
    chk({p, ".resp_rdata"}, resp_rdata, 64'd0);
    chk({p, ".resp_err"}, 64'(resp_err), 64'(0));
    chk({p, ".dm_addr"}, dm_addr, 64'd0);
    chk({p, ".dm_din"}, dm_din, 64'd0);
    chk({p, ".dm_rd_ctrl"}, 64'(dm_rd_ctrl), 64'(0));
    chk({p, ".dm_wr_ctrl"}, 64'(dm_wr_ctrl), 64'(0));
    chk({p, ".req_ready"}, 64'(req_ready), 64'(1));
  endtask

  initial begin
    logic ok;
    int unsigned n;
    rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset("reset");

    //      name          ld    st    f3      addr              wdata                  exp rdata              err    rc      wc    stall
    issue("sd_100",      1'b0, 1'b1, 3'b011, 64'h8000_0100, 64'h1122_3344_5566_7788, 64'h0,                 2'b00, 3'd0, 3'd4, 0);
    issue("ld_100",      1'b1, 1'b0, 3'b011, 64'h8000_0100, 64'h0, 64'h1122_3344_5566_7788,                 2'b00, 3'd7, 3'd0, 0);
    issue("sb_107",      1'b0, 1'b1, 3'b000, 64'h8000_0107, 64'h80,                  64'h0,                 2'b00, 3'd0, 3'd1, 0);
    issue("lb_107",      1'b1, 1'b0, 3'b000, 64'h8000_0107, 64'h0, 64'hFFFF_FFFF_FFFF_FF80,                 2'b00, 3'd1, 3'd0, 0);
    issue("lbu_107",     1'b1, 1'b0, 3'b100, 64'h8000_0107, 64'h0, 64'h80,                                  2'b00, 3'd2, 3'd0, 0);
    issue("lh_mis",      1'b1, 1'b0, 3'b001, 64'h8000_0101, 64'h0, 64'h0,                                   2'b01, 3'd0, 3'd0, 0);
    issue("ld_f3_111",   1'b1, 1'b0, 3'b111, 64'h8000_0100, 64'h0, 64'h0,                                   2'b10, 3'd0, 3'd0, 0);
    issue("ld_and_st",   1'b1, 1'b1, 3'b011, 64'h8000_0100, 64'h0, 64'h0,                                   2'b10, 3'd0, 3'd0, 0);
    issue("neither",     1'b0, 1'b0, 3'b000, 64'h8000_0100, 64'h0, 64'h0,                                   2'b10, 3'd0, 3'd0, 0);
    issue("st_f3_100",   1'b0, 1'b1, 3'b100, 64'h8000_0100, 64'h0, 64'h0,                                   2'b10, 3'd0, 3'd0, 0);
    issue("sw_mis",      1'b0, 1'b1, 3'b010, 64'h8000_0102, 64'h0, 64'h0,                                   2'b01, 3'd0, 3'd0, 0);
    issue("ld_mis",      1'b1, 1'b0, 3'b011, 64'h8000_0104, 64'h0, 64'h0,                                   2'b01, 3'd0, 3'd0, 0);
    issue("lw_stall",    1'b1, 1'b0, 3'b010, 64'h8000_0100, 64'h0, 64'h0000_0000_5566_7788,                 2'b00, 3'd5, 3'd0, 5);
    issue("lwu_104",     1'b1, 1'b0, 3'b110, 64'h8000_0104, 64'h0, 64'h0000_0000_8022_3344,                 2'b00, 3'd6, 3'd0, 0);
    issue("lw_104",      1'b1, 1'b0, 3'b010, 64'h8000_0104, 64'h0, 64'hFFFF_FFFF_8022_3344,                 2'b00, 3'd5, 3'd0, 0);
    issue("lh_106",      1'b1, 1'b0, 3'b001, 64'h8000_0106, 64'h0, 64'hFFFF_FFFF_FFFF_8022,                 2'b00, 3'd3, 3'd0, 0);
    issue("lhu_106",     1'b1, 1'b0, 3'b101, 64'h8000_0106, 64'h0, 64'h0000_0000_0000_8022,                 2'b00, 3'd4, 3'd0, 0);
    issue("sd_200",      1'b0, 1'b1, 3'b011, 64'h8000_0200, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0,                 2'b00, 3'd0, 3'd4, 0);

    // sw at 0x200 cut by reset during its access cycle.
    wait_ready("rst_sw", ok);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 64'h8000_0200; req_wdata = 64'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("rst_sw.wr_ctrl_forced", 64'(dm_wr_ctrl), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset("rst_sw");

    issue("ld_200",      1'b1, 1'b0, 3'b011, 64'h8000_0200, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA,                 2'b00, 3'd7, 3'd0, 0);
    issue("sh_202",      1'b0, 1'b1, 3'b001, 64'h8000_0202, 64'hBEEF,                64'h0,                 2'b00, 3'd0, 3'd2, 0);
    issue("ld_200_b",    1'b1, 1'b0, 3'b011, 64'h8000_0200, 64'h0, 64'hAAAA_AAAA_BEEF_AAAA,                 2'b00, 3'd7, 3'd0, 0);

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
